coef_loader: RTL

- Upstream neighbour of control_v2 in the FIFO/ADC/FIR chain.
- While reception is enabled, it takes UART receive bytes, assembles them into signed 12-bit FIR coefficients and stores N_COEF of them in a register bank.
- It presents the bank to the FIR and raises fin_block_coef_o, which feeds control_v2's fin_block_coef_i, once the full block has arrived.

---
 rtl/fir_pkg.sv | 39 +++
 rtl/coef_loader_byte_to_coef_12.sv | 14 +
 rtl/coef_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR-chain definitions: coefficient geometry, loader FSM encoding and
// the byte-pair to 12-bit coefficient assembly rule (COEF_LOADER_CHKSUM_EN adds WAIT_CHK).
package fir_pkg;

  localparam int unsigned N_COEF = 16;
  localparam int unsigned COEF_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HI_W   = COEF_W - BYTE_W;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_LO  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_HI  = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_CHK = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_WAIT_LO  = ST_WAIT_LO,
    S_WAIT_HI  = ST_WAIT_HI,
`ifdef COEF_LOADER_CHKSUM_EN
    S_WAIT_CHK = ST_WAIT_CHK,
`endif
    S_DONE     = ST_DONE
  } state_e;

  // Low nibble of the high byte carries coefficient bits [11:8].
  function automatic logic [COEF_W-1:0] assemble_coef(input logic [BYTE_W-1:0] lo,
                                                      input logic [BYTE_W-1:0] hi);
    return {hi[HI_W-1:0], lo};
  endfunction

  // Upper nibble must be a pure sign extension of coefficient bit 11.
  function automatic logic hi_nibble_ok(input logic [BYTE_W-1:0] hi);
    return hi[BYTE_W-1:HI_W] == {(BYTE_W-HI_W){hi[HI_W-1]}};
  endfunction

endpackage

// File: rtl/coef_loader_byte_to_coef_12.sv
// Combinational 8+8 -> 12 coefficient assembler with sign-nibble check.
module byte_to_coef_12
  import fir_pkg::*;
(
  input  logic [BYTE_W-1:0] lo_i,
  input  logic [BYTE_W-1:0] hi_i,
  output logic [COEF_W-1:0] coef_o,
  output logic              nib_ok_o
);

  assign coef_o   = assemble_coef(lo_i, hi_i);
  assign nib_ok_o = hi_nibble_ok(hi_i);

endmodule

// File: rtl/coef_loader.sv
// UART byte stream -> bank of N_COEF signed coefficients for the FIR.
// Define COEF_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module coef_loader
  import fir_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_recepcion_i,
  input  logic [BYTE_W-1:0]        rx_data_i,
  input  logic                     rx_valid_i,
  output logic [N_COEF*COEF_W-1:0] coef_o,
  output logic                     coef_wr_o,
  output logic [IDX_W-1:0]         coef_addr_o,
  output logic [COEF_W-1:0]        coef_data_o,
  output logic                     fin_block_coef_o,
  output logic                     err_o
);

  state_e              state_q, state_d;
  logic                en_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [COEF_W-1:0]   bank_q [N_COEF];
  logic [COEF_W-1:0]   bank_d [N_COEF];
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic [COEF_W-1:0]   data_q, data_d;
  logic                fin_q, fin_d;
  logic                err_q, err_d;
`ifdef COEF_LOADER_CHKSUM_EN
  logic [BYTE_W-1:0]   xor_q, xor_d;
`endif

  logic                start_c;
  logic [COEF_W-1:0]   coef_c;
  logic                nib_ok_c;

  assign start_c = en_recepcion_i & ~en_q;

  byte_to_coef_12 u_asm (
    .lo_i     (lo_q),
    .hi_i     (rx_data_i),
    .coef_o   (coef_c),
    .nib_ok_o (nib_ok_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    bank_d  = bank_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    fin_d   = fin_q;
    err_d   = err_q;
`ifdef COEF_LOADER_CHKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_c) begin
          state_d = S_WAIT_LO;
          idx_d   = '0;
          fin_d   = 1'b0;
          err_d   = 1'b0;
`ifdef COEF_LOADER_CHKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_WAIT_LO: begin
        if (!en_recepcion_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          lo_d    = rx_data_i;
          state_d = S_WAIT_HI;
`ifdef COEF_LOADER_CHKSUM_EN
          xor_d   = xor_q ^ rx_data_i;
`endif
        end
      end
      S_WAIT_HI: begin
        if (!en_recepcion_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          bank_d[idx_q] = coef_c;
          wr_d          = 1'b1;
          addr_d        = idx_q;
          data_d        = coef_c;
          if (!nib_ok_c) err_d = 1'b1;
`ifdef COEF_LOADER_CHKSUM_EN
          xor_d         = xor_q ^ rx_data_i;
`endif
          if (idx_q == IDX_W'(N_COEF - 1)) begin
`ifdef COEF_LOADER_CHKSUM_EN
            state_d = S_WAIT_CHK;
`else
            state_d = S_DONE;
            fin_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_WAIT_LO;
          end
        end
      end
`ifdef COEF_LOADER_CHKSUM_EN
      S_WAIT_CHK: begin
        if (!en_recepcion_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          if (rx_data_i == xor_q) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      idx_q   <= '0;
      lo_q    <= '0;
      for (int k = 0; k < int'(N_COEF); k++) bank_q[k] <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef COEF_LOADER_CHKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_recepcion_i;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      bank_q  <= bank_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
`ifdef COEF_LOADER_CHKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Flatten the bank: coefficient k at bits [k*COEF_W +: COEF_W].
  for (genvar k = 0; k < int'(N_COEF); k++) begin : g_flat
    assign coef_o[k*COEF_W +: COEF_W] = bank_q[k];
  end

  assign coef_wr_o        = wr_q;
  assign coef_addr_o      = addr_q;
  assign coef_data_o      = data_q;
  assign fin_block_coef_o = fin_q;
  assign err_o            = err_q;

endmodule
